// File: rtl/l2_line_responder.sv
// Line-wide backing memory behind the L1 D-cache: serves line fills and absorbs
// dirty-line writebacks, each answered a fixed number of cycles after its request edge.
module l2_line_responder #(
   parameter int data_width    = 32,
   parameter int address_width = 32,
   parameter int block_size    = 32,
   parameter int mem_depth     = 1024,
   parameter int latency       = 4,
   localparam int line_width   = block_size * data_width,
   localparam int offset_width = $clog2(data_width * block_size / 8),
   localparam int laddr_width  = address_width - offset_width,
   localparam int index_width  = $clog2(mem_depth)
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   ADDR_FROM_L1_VALID,
   input  logic [laddr_width-1:0] ADDR_FROM_L1,
   output logic [line_width-1:0]  DATA_TO_L1,
   output logic                   DATA_TO_L1_VALID,
   input  logic                   DATA_FROM_L1_VALID,
   input  logic [line_width-1:0]  DATA_FROM_L1,
   input  logic [laddr_width-1:0] WADDR_FROM_L1,
   output logic                   WRITE_DONE,
   output logic                   PROTO_ERR
);

   typedef enum logic [2:0] {IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_DONE} state_t;

   localparam logic [7:0] cnt_init = 8'(latency - 1);
   localparam bit         lat_one  = (latency == 1);

   logic [line_width-1:0]  mem [mem_depth];
   state_t                 state;
   logic [7:0]             cnt;
   logic                   rd_prev, wr_prev, pend_vld;
   logic [index_width-1:0] pend_idx, rd_idx, wr_idx;
   logic [line_width-1:0]  wr_data;
   logic                   rd_edge, wr_edge, serve, slot_req;
   logic [index_width-1:0] req_idx, wreq_idx, serve_idx, rd_fire_idx, wr_fire_idx;
   logic                   rd_fire, wr_fire;
   logic [line_width-1:0]  wr_fire_data;
   logic                   unused_hi;

   // Upper line-address bits alias onto the same storage line.
   assign unused_hi = ^{ADDR_FROM_L1[laddr_width-1:index_width],
                        WADDR_FROM_L1[laddr_width-1:index_width]};

   always_comb begin
      rd_edge      = ADDR_FROM_L1_VALID & ~rd_prev;
      wr_edge      = DATA_FROM_L1_VALID & ~wr_prev;
      req_idx      = ADDR_FROM_L1[index_width-1:0];
      wreq_idx     = WADDR_FROM_L1[index_width-1:0];
      serve        = pend_vld | rd_edge;
      serve_idx    = pend_vld ? pend_idx : req_idx;
      slot_req     = rd_edge & ((state != IDLE) | wr_edge);
      rd_fire      = 1'b0;
      rd_fire_idx  = rd_idx;
      wr_fire      = 1'b0;
      wr_fire_idx  = wr_idx;
      wr_fire_data = wr_data;
      // The fire strobes mark the clock edge that enters RD_RESP / WR_DONE.
      if (RST) begin
         case (state)
            IDLE: begin
               if (wr_edge) begin
                  wr_fire      = lat_one;
                  wr_fire_idx  = wreq_idx;
                  wr_fire_data = DATA_FROM_L1;
               end else if (serve) begin
                  rd_fire      = lat_one;
                  rd_fire_idx  = serve_idx;
               end
            end
            RD_WAIT: rd_fire = (cnt == 8'd1);
            WR_WAIT: wr_fire = (cnt == 8'd1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (wr_fire) mem[wr_fire_idx] <= wr_fire_data;
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state            <= IDLE;
         cnt              <= 8'd0;
         rd_prev          <= 1'b0;
         wr_prev          <= 1'b0;
         pend_vld         <= 1'b0;
         DATA_TO_L1       <= '0;
         DATA_TO_L1_VALID <= 1'b0;
         WRITE_DONE       <= 1'b0;
         PROTO_ERR        <= 1'b0;
      end else begin
         rd_prev          <= ADDR_FROM_L1_VALID;
         wr_prev          <= DATA_FROM_L1_VALID;
         DATA_TO_L1_VALID <= rd_fire;
         WRITE_DONE       <= wr_fire;
         if (rd_fire) DATA_TO_L1 <= mem[rd_fire_idx];

         // Reads arriving while busy (or alongside a writeback) park in the one-deep slot.
         if (slot_req) begin
            if (!pend_vld) begin
               pend_vld <= 1'b1;
               pend_idx <= req_idx;
            end else begin
               PROTO_ERR <= 1'b1;
            end
         end
         if (wr_edge && state != IDLE) PROTO_ERR <= 1'b1;

         case (state)
            IDLE: begin
               if (wr_edge) begin
                  wr_idx  <= wreq_idx;
                  wr_data <= DATA_FROM_L1;
                  cnt     <= cnt_init;
                  state   <= lat_one ? WR_DONE : WR_WAIT;
               end else if (serve) begin
                  rd_idx  <= serve_idx;
                  cnt     <= cnt_init;
                  state   <= lat_one ? RD_RESP : RD_WAIT;
                  if (pend_vld) begin
                     if (rd_edge) pend_idx <= req_idx;
                     else         pend_vld <= 1'b0;
                  end
               end
            end
            RD_WAIT: begin
               cnt <= cnt - 8'd1;
               if (cnt == 8'd1) state <= RD_RESP;
            end
            WR_WAIT: begin
               cnt <= cnt - 8'd1;
               if (cnt == 8'd1) state <= WR_DONE;
            end
            RD_RESP: state <= IDLE;
            WR_DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_l2_line_responder.sv
// Bench for l2_line_responder: a latency-4 and a latency-1 instance share stimulus;
// a scoreboard of expected response cycles/data is checked against the selected instance.
module tb_l2_line_responder;

   localparam int DW = 32, AW = 32, BS = 2, MD = 16;
   localparam int LW = BS * DW;
   localparam int LAW = AW - $clog2(DW * BS / 8);

   typedef struct {
      int unsigned     cyc;
      logic [LW-1:0]   data;
   } rd_exp_t;

   logic            clk = 1'b0;
   logic            rst;
   logic            av, dv;
   logic [LAW-1:0]  addr, waddr;
   logic [LW-1:0]   wdata;
   logic [LW-1:0]   d4, d1;
   logic            rv4, rv1, wd4, wd1, pe4, pe1;
   logic            sel;
   logic [LW-1:0]   m_d;
   logic            m_rv, m_wd;

   int unsigned     cyc = 0;
   int              lat;
   int              total = 0;
   int              bad = 0;
   rd_exp_t         rq[$];
   int unsigned     wq[$];
   logic [LW-1:0]   model [MD];

   localparam logic [LW-1:0] PAT_A = 64'hA5A5_0001_5A5A_1111;
   localparam logic [LW-1:0] PAT_B = 64'hBEEF_0002_CAFE_2222;
   localparam logic [LW-1:0] PAT_C = 64'hC3C3_0003_3C3C_3333;
   localparam logic [LW-1:0] PAT_D = 64'hD00D_0004_F00D_4444;
   localparam logic [LW-1:0] PAT_E = 64'hE1E1_0005_1E1E_5555;
   localparam logic [LW-1:0] PAT_F = 64'hF0F0_0006_0F0F_6666;
   localparam logic [LW-1:0] PAT_G = 64'h1234_0007_5678_7777;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   l2_line_responder #(.data_width(DW), .address_width(AW), .block_size(BS),
                       .mem_depth(MD), .latency(4)) dut4 (
      .CLK(clk), .RST(rst),
      .ADDR_FROM_L1_VALID(av), .ADDR_FROM_L1(addr),
      .DATA_TO_L1(d4), .DATA_TO_L1_VALID(rv4),
      .DATA_FROM_L1_VALID(dv), .DATA_FROM_L1(wdata), .WADDR_FROM_L1(waddr),
      .WRITE_DONE(wd4), .PROTO_ERR(pe4));

   l2_line_responder #(.data_width(DW), .address_width(AW), .block_size(BS),
                       .mem_depth(MD), .latency(1)) dut1 (
      .CLK(clk), .RST(rst),
      .ADDR_FROM_L1_VALID(av), .ADDR_FROM_L1(addr),
      .DATA_TO_L1(d1), .DATA_TO_L1_VALID(rv1),
      .DATA_FROM_L1_VALID(dv), .DATA_FROM_L1(wdata), .WADDR_FROM_L1(waddr),
      .WRITE_DONE(wd1), .PROTO_ERR(pe1));

   assign m_d  = sel ? d1  : d4;
   assign m_rv = sel ? rv1 : rv4;
   assign m_wd = sel ? wd1 : wd4;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_rd(input int a);
      addr = LAW'(a);
      av   = 1'b1;
      tick(1);
      av   = 1'b0;
   endtask

   task automatic rd(input int a);
      rq.push_back('{cyc: cyc + lat, data: model[a]});
      pulse_rd(a);
   endtask

   task automatic wr(input int a, input logic [LW-1:0] d, input bit commit);
      if (commit) begin
         wq.push_back(cyc + lat);
         model[a] = d;
      end
      waddr = LAW'(a);
      wdata = d;
      dv    = 1'b1;
      tick(1);
      dv    = 1'b0;
   endtask

   task automatic both(input int a, input logic [LW-1:0] d);
      wq.push_back(cyc + lat);
      rq.push_back('{cyc: cyc + 2 * lat + 1, data: d});
      model[a] = d;
      addr  = LAW'(a);
      waddr = LAW'(a);
      wdata = d;
      av    = 1'b1;
      dv    = 1'b1;
      tick(1);
      av    = 1'b0;
      dv    = 1'b0;
   endtask

   // Scoreboard: every response pulse must match the oldest expectation, cycle and data.
   always @(negedge clk) begin
      if (m_rv) begin
         if (rq.size() == 0) chk("rd_unexpected", 64'(m_rv), 64'd0);
         else begin
            rd_exp_t e;
            e = rq.pop_front();
            chk("rd_cycle", 64'(cyc), 64'(e.cyc));
            chk("rd_data", m_d, e.data);
         end
      end
      if (m_wd) begin
         if (wq.size() == 0) chk("wd_unexpected", 64'(m_wd), 64'd0);
         else chk("wd_cycle", 64'(cyc), 64'(wq.pop_front()));
      end
   end

   initial begin
      int unsigned t0;
      foreach (model[i]) model[i] = '0;
      rst = 1'b0; av = 1'b0; dv = 1'b0; addr = '0; waddr = '0; wdata = '0;
      sel = 1'b0; lat = 4;
      tick(3);
      chk("rst_data", d4, 64'd0);
      chk("rst_rvalid", 64'(rv4), 64'd0);
      chk("rst_wdone", 64'(wd4), 64'd0);
      chk("rst_perr", 64'(pe4), 64'd0);
      rst = 1'b1;
      tick(2);

      wr(5, PAT_A, 1'b1);  tick(6);
      rd(5);               tick(6);
      chk("hold_data", d4, PAT_A);
      wr(7, PAT_B, 1'b1);  tick(6);
      rd(7);               tick(6);

      both(7, PAT_C);      tick(12);
      chk("simul_perr", 64'(pe4), 64'd0);

      rq.push_back('{cyc: cyc + lat, data: model[5]});
      addr = LAW'(5);
      av   = 1'b1;
      tick(6);
      av   = 1'b0;
      tick(6);

      wr(9, PAT_D, 1'b1);  tick(6);
      wr(9, PAT_E, 1'b0);
      tick(1);
      rst = 1'b0;
      tick(1);
      chk("midrst_data", d4, 64'd0);
      chk("midrst_rvalid", 64'(rv4), 64'd0);
      chk("midrst_wdone", 64'(wd4), 64'd0);
      chk("midrst_perr", 64'(pe4), 64'd0);
      tick(1);
      rst = 1'b1;
      tick(2);
      rd(9);               tick(6);

      t0 = cyc;
      rq.push_back('{cyc: t0 + lat, data: model[5]});
      rq.push_back('{cyc: t0 + 2 * lat + 1, data: model[7]});
      pulse_rd(5);  tick(1);
      pulse_rd(7);  tick(1);
      chk("perr_before", 64'(pe4), 64'd0);
      pulse_rd(9);
      chk("perr_set", 64'(pe4), 64'd1);
      tick(12);
      chk("perr_sticky", 64'(pe4), 64'd1);
      rst = 1'b0;
      tick(2);
      chk("perr_cleared", 64'(pe4), 64'd0);
      rst = 1'b1;
      tick(2);
      chk("p1_rq_left", 64'(rq.size()), 64'd0);
      chk("p1_wq_left", 64'(wq.size()), 64'd0);

      sel = 1'b1; lat = 1;
      chk("p2_perr", 64'(pe1), 64'd0);
      wr(3, PAT_F, 1'b1);  tick(3);
      rd(3);               tick(3);
      chk("p2_hold", d1, PAT_F);
      both(3, PAT_G);      tick(5);
      rd(3);               tick(3);
      chk("p2_rq_left", 64'(rq.size()), 64'd0);
      chk("p2_wq_left", 64'(wq.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/l2_line_responder.md
Name: l2_line_responder

Overview:
- Memory-side responder for the L1 data cache's line interface. It serves line-fill read requests and accepts dirty-line writebacks.
- Backing storage is a line-wide array with a fixed, parameterised response latency.
- It is used as the L2/backing-memory model behind the D-cache in the core subsystem and in cache-level testbenches.

Parameters:
- data_width, 32, word width in bits.
- address_width, 32, byte address width.
- block_size, 32, words per line. Derived: line_width = block_size*data_width; offset_width = log2(data_width*block_size/8); laddr_width = address_width - offset_width.
- mem_depth, 1024, lines of backing storage. Derived: index_width = log2(mem_depth).
- latency, 4, cycles from request capture to response. Legal range 1..255.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset; one clock; reset is synchronous and active-low.
- ADDR_FROM_L1_VALID  in  1  line-fill request strobe.
- ADDR_FROM_L1  in  laddr_width  line address of the fill.
- DATA_TO_L1  out  line_width  fill data.
- DATA_TO_L1_VALID  out  1  fill data valid, one-cycle pulse.
- DATA_FROM_L1_VALID  in  1  writeback strobe.
- DATA_FROM_L1  in  line_width  writeback line data.
- WADDR_FROM_L1  in  laddr_width  writeback line address.
- WRITE_DONE  out  1  writeback committed, one-cycle pulse.
- PROTO_ERR  out  1  sticky protocol-violation flag.

Behaviour:
- Storage index is line address [index_width-1:0]; upper bits are ignored (aliasing allowed).
- Array contents are not affected by RST and are zero-initialised at time 0.
- Request detection: a read request is the rising edge of ADDR_FROM_L1_VALID (high now, low last cycle); a writeback is the rising edge of DATA_FROM_L1_VALID. Holding a strobe high for N cycles yields one request.
- Address and data are captured in the edge cycle.
- FSM states: IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_DONE. The down-counter cnt is 8 bits.
- IDLE: a writeback edge -> capture addr/data, cnt=latency-1, go to WR_WAIT. Otherwise a read edge or a valid pending read -> capture/consume it, cnt=latency-1, go to RD_WAIT.
- Simultaneous read and writeback edges: the writeback is served first and the read goes to the pending slot. A later read of the same line therefore returns the written data.
- RD_WAIT: decrement cnt; at cnt==0 go to RD_RESP.
- RD_RESP: DATA_TO_L1 = array[index] read this cycle, DATA_TO_L1_VALID=1 for exactly this one cycle, then IDLE.
- WR_WAIT: decrement cnt; at cnt==0 go to WR_DONE.
- WR_DONE: array[index] written with captured data, WRITE_DONE=1 for exactly this one cycle, then IDLE.
- Latency: with request edge at cycle T, the response pulse is at cycle T+latency. For latency=1, RD_WAIT/WR_WAIT are skipped (IDLE goes straight to the response state).
- Pending slot: one-deep, holds a read only. A read edge while not in IDLE (or during a simultaneous writeback) fills the slot if empty. If the slot is full, PROTO_ERR is set and the request is dropped.
- A writeback edge while not IDLE sets PROTO_ERR and is dropped. The L1 never issues one while busy, because its writing flag blocks it.
- After a response, IDLE serves the pending read on the next cycle. Back-to-back reads therefore cost latency+1 cycles each.
- DATA_TO_L1 holds its last value between pulses. Nothing outside RD_RESP drives it.
- Reset values: DATA_TO_L1=0, DATA_TO_L1_VALID=0, WRITE_DONE=0, PROTO_ERR=0, state=IDLE, cnt=0, pending slot empty, edge-detect history=0.
- Reset mid-operation: the in-flight request is abandoned. An uncommitted writeback is not written; an already-committed write is retained.
- PROTO_ERR clears only on reset.

Test Plan:
- latency=4, preload line 5 = pattern A, one-cycle read pulse of addr 5 at cycle 10 -> DATA_TO_L1=A with DATA_TO_L1_VALID high at cycle 14 only.
- Writeback of line 7 = pattern B at cycle 20, then read of 7 after WRITE_DONE -> WRITE_DONE at cycle 24; read returns B, not the zero init.
- Read (line 7) and writeback (line 7, pattern C) edges in the same cycle T -> WRITE_DONE at T+4; DATA_TO_L1=C with valid at T+9; PROTO_ERR stays 0.
- ADDR_FROM_L1_VALID held high 6 cycles -> exactly one DATA_TO_L1_VALID pulse.
- Writeback in flight; drive RST=0 at cycle T+2 and release -> no WRITE_DONE; the line still reads old contents; all outputs are 0 during reset.
- Three read edges during one busy period -> the first two are served; PROTO_ERR=1 after the third and stays set until reset. Rerun with latency=1: response pulse on T+1.
